// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them to
// instruction memory, and holds the core halted until the load completes.
module imem_loader #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              halt_reg,
  output logic              busy,
  output logic              done,
  output logic              bad_op,
  output logic              halt_seen
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [6:0] OP_HALT = 7'b0000001;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              halt_q, halt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bad_q, bad_d;
  logic              hseen_q, hseen_d;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0000001, 7'b0110111: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  endfunction

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    word_cnt_d = word_cnt_q;
    target_d   = target_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    halt_d     = halt_q;
    bad_d      = bad_q;
    hseen_d    = hseen_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d   = (num_words > DEPTH) ? DEPTH : num_words;
          word_cnt_d = '0;
          byte_idx_d = '0;
          addr_d     = '0;
          bad_d      = 1'b0;
          hseen_d    = 1'b0;
          halt_d     = 1'b1;
          if (num_words == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            halt_d  = 1'b0;
          end else begin
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (in_valid) begin
          case (byte_idx_q)
            2'd0:    word_d[7:0]   = in_data;
            2'd1:    word_d[15:8]  = in_data;
            2'd2:    word_d[23:16] = in_data;
            default: word_d[31:24] = in_data;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = WRITE;
            we_d    = 1'b1;
            wdata_d = word_d;
          end
        end
      end
      WRITE: begin
        bad_d      = bad_q | ~op_legal(wdata_q[6:0]);
        hseen_d    = hseen_q | (wdata_q[6:0] == OP_HALT);
        word_cnt_d = word_cnt_q + CNT_W'(1);
        if (word_cnt_q + CNT_W'(1) == target_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          halt_d  = 1'b0;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      word_q     <= '0;
      word_cnt_q <= '0;
      target_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      halt_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      hseen_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      word_cnt_q <= word_cnt_d;
      target_q   <= target_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      halt_q     <= halt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
      hseen_q    <= hseen_d;
    end
  end

  assign in_ready   = (state_q == RECV);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign halt_reg   = halt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bad_op     = bad_q;
  assign halt_seen  = hseen_q;

endmodule
